// File: rtl/anycore_l15_pkg.sv
`default_nettype none
// ============================================================================
// Package  : anycore_l15_pkg
// Desc     : Shared request types, size codes and request struct for the
//            core-to-L1.5 request path.
// Revision : 1.0 - initial release
// ============================================================================
package anycore_l15_pkg;

    localparam int ARB_CHID_W  = 3;
    localparam int RQTYPE_W    = 5;
    localparam int PCX_SIZE_W  = 3;
    localparam int REQ_ADDR_W  = 40;
    localparam int REQ_DATA_W  = 64;

    // Request type encodings shared with iop.h
    localparam logic [RQTYPE_W-1:0] LOAD_RQ    = 5'b00000;
    localparam logic [RQTYPE_W-1:0] IMISS_RQ   = 5'b10000;
    localparam logic [RQTYPE_W-1:0] STORE_RQ   = 5'b00001;
    localparam logic [RQTYPE_W-1:0] CAS1_RQ    = 5'b00010;
    localparam logic [RQTYPE_W-1:0] CAS2_RQ    = 5'b00011;
    localparam logic [RQTYPE_W-1:0] STRLOAD_RQ = 5'b00100;
    localparam logic [RQTYPE_W-1:0] STRST_RQ   = 5'b00101;
    localparam logic [RQTYPE_W-1:0] SWAP_RQ    = 5'b00110;
    localparam logic [RQTYPE_W-1:0] INT_RQ     = 5'b01001;

    localparam logic [PCX_SIZE_W-1:0] PCX_SZ_1B  = 3'b000;
    localparam logic [PCX_SIZE_W-1:0] PCX_SZ_2B  = 3'b001;
    localparam logic [PCX_SIZE_W-1:0] PCX_SZ_4B  = 3'b010;
    localparam logic [PCX_SIZE_W-1:0] PCX_SZ_8B  = 3'b011;
    localparam logic [PCX_SIZE_W-1:0] PCX_SZ_16B = 3'b111;

    typedef struct packed {
        logic [RQTYPE_W-1:0]   rqtype;
        logic [PCX_SIZE_W-1:0] size;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] data;
    } l15_req_t;

endpackage
`default_nettype wire

// File: rtl/anycore_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : anycore_req_fifo
// Desc     : Per-channel request FIFO; full/empty decoded from a count register.
// Revision : 1.0 - initial release
// ============================================================================
module anycore_req_fifo
    import anycore_l15_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  l15_req_t push_req,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output l15_req_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    l15_req_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    // A full FIFO refuses a push even when it pops in the same cycle
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign head      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/anycore_l15_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : anycore_l15_req_arbiter
// Desc     : Multi-channel request FIFOs, arbiter and registered L1.5 request
//            stage. ANYCORE_ARB_RR_EN selects round-robin, else fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module anycore_l15_req_arbiter
    import anycore_l15_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 4,
    parameter int PA_W   = 40
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CH-1:0]      ch_val,
    output logic [NUM_CH-1:0]      ch_rdy,
    input  logic [5*NUM_CH-1:0]    ch_rqtype,
    input  logic [3*NUM_CH-1:0]    ch_size,
    input  logic [PA_W*NUM_CH-1:0] ch_addr,
    input  logic [64*NUM_CH-1:0]   ch_data,
    input  logic                   l15_transducer_ack,
    output logic                   arb_l15_val,
    output logic [4:0]             arb_l15_rqtype,
    output logic [2:0]             arb_l15_size,
    output logic [PA_W-1:0]        arb_l15_address,
    output logic [63:0]            arb_l15_data,
    output logic                   arb_l15_nc,
    output logic [2:0]             arb_l15_chid,
    output logic                   arb_err_spurious_ack
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    arb_state_e              r_state;
    arb_state_e              w_state_nxt;
    l15_req_t                r_req;
    l15_req_t                w_req_nxt;
    logic [ARB_CHID_W-1:0]   r_chid;
    logic [ARB_CHID_W-1:0]   w_chid_nxt;
    logic                    r_err;

    l15_req_t                w_head [NUM_CH];
    logic [NUM_CH-1:0]       w_full;
    logic [NUM_CH-1:0]       w_empty;
    logic [NUM_CH-1:0]       w_pop;

    logic                    w_grant_vld;
    logic [ARB_CHID_W-1:0]   w_grant_idx;
    l15_req_t                w_grant_req;
    logic                    w_load;
    logic [PA_W-1:0]         w_addr;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        l15_req_t w_push_req;

        assign w_push_req = '{rqtype: ch_rqtype[i*RQTYPE_W +: RQTYPE_W],
                              size:   ch_size[i*PCX_SIZE_W +: PCX_SIZE_W],
                              addr:   REQ_ADDR_W'(ch_addr[i*PA_W +: PA_W]),
                              data:   ch_data[i*REQ_DATA_W +: REQ_DATA_W]};
        assign ch_rdy[i]  = ~w_full[i];
        assign w_pop[i]   = w_load & (w_grant_idx == ARB_CHID_W'(i));

        anycore_req_fifo #(
            .DEPTH    (DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .push     (ch_val[i]),
            .push_req (w_push_req),
            .pop      (w_pop[i]),
            .full     (w_full[i]),
            .empty    (w_empty[i]),
            .head     (w_head[i])
        );
    end

`ifdef ANYCORE_ARB_RR_EN
    // Points at the channel searched first: one past the last grant
    logic [ARB_CHID_W-1:0] r_rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_load) begin
            r_rr_ptr <= (w_grant_idx == ARB_CHID_W'(NUM_CH - 1)) ? '0
                                                                 : w_grant_idx + ARB_CHID_W'(1);
        end
    end
`endif

    // Winner is the valid head with the smallest search distance
    always_comb begin
        int v_dist;
        int v_best;
        v_dist      = 0;
        v_best      = NUM_CH;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_grant_req = '0;
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef ANYCORE_ARB_RR_EN
            v_dist = i - int'(r_rr_ptr);
            if (v_dist < 0) begin
                v_dist = v_dist + NUM_CH;
            end
`else
            v_dist = i;
`endif
            if (!w_empty[i] && (v_dist < v_best)) begin
                v_best      = v_dist;
                w_grant_vld = 1'b1;
                w_grant_idx = ARB_CHID_W'(i);
                w_grant_req = w_head[i];
            end
        end
    end

    assign w_load = w_grant_vld & ((r_state == ST_IDLE) | l15_transducer_ack);

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_chid_nxt  = r_chid;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_vld) begin
                    w_state_nxt = ST_BUSY;
                    w_req_nxt   = w_grant_req;
                    w_chid_nxt  = w_grant_idx;
                end
            end
            ST_BUSY: begin
                if (l15_transducer_ack) begin
                    if (w_grant_vld) begin
                        w_req_nxt  = w_grant_req;
                        w_chid_nxt = w_grant_idx;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_req_nxt   = '0;
                        w_chid_nxt  = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_req_nxt   = '0;
                w_chid_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_req   <= '0;
            r_chid  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_chid  <= w_chid_nxt;
            r_err   <= r_err | (l15_transducer_ack & (r_state == ST_IDLE));
        end
    end

    assign w_addr               = PA_W'(r_req.addr);
    assign arb_l15_val          = (r_state == ST_BUSY);
    assign arb_l15_rqtype       = r_req.rqtype;
    assign arb_l15_size         = r_req.size;
    assign arb_l15_address      = w_addr;
    assign arb_l15_data         = r_req.data;
    assign arb_l15_nc           = w_addr[PA_W-1];
    assign arb_l15_chid         = r_chid;
    assign arb_err_spurious_ack = r_err;

endmodule
`default_nettype wire

// File: tb/tb_anycore_l15_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_anycore_l15_req_arbiter
// Desc     : Scoreboard bench for the L1.5 request arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_anycore_l15_req_arbiter;

    localparam int NUM_CH = 4;
    localparam int DEPTH  = 4;
    localparam int PA_W   = 40;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NUM_CH-1:0]      ch_val;
    logic [NUM_CH-1:0]      ch_rdy;
    logic [5*NUM_CH-1:0]    ch_rqtype;
    logic [3*NUM_CH-1:0]    ch_size;
    logic [PA_W*NUM_CH-1:0] ch_addr;
    logic [64*NUM_CH-1:0]   ch_data;
    logic                   ack;
    logic                   arb_l15_val;
    logic [4:0]             arb_l15_rqtype;
    logic [2:0]             arb_l15_size;
    logic [PA_W-1:0]        arb_l15_address;
    logic [63:0]            arb_l15_data;
    logic                   arb_l15_nc;
    logic [2:0]             arb_l15_chid;
    logic                   arb_err_spurious_ack;

    typedef struct {
        logic [4:0]  rqtype;
        logic [2:0]  size;
        logic [39:0] addr;
        logic [63:0] data;
    } tb_req_t;

    tb_req_t exp_q [NUM_CH][$];
    int      exp_chid_q [$];
    int      n_checks = 0;
    int      n_fail   = 0;

    anycore_l15_req_arbiter #(
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH),
        .PA_W   (PA_W)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .ch_val               (ch_val),
        .ch_rdy               (ch_rdy),
        .ch_rqtype            (ch_rqtype),
        .ch_size              (ch_size),
        .ch_addr              (ch_addr),
        .ch_data              (ch_data),
        .l15_transducer_ack   (ack),
        .arb_l15_val          (arb_l15_val),
        .arb_l15_rqtype       (arb_l15_rqtype),
        .arb_l15_size         (arb_l15_size),
        .arb_l15_address      (arb_l15_address),
        .arb_l15_data         (arb_l15_data),
        .arb_l15_nc           (arb_l15_nc),
        .arb_l15_chid         (arb_l15_chid),
        .arb_err_spurious_ack (arb_err_spurious_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue monitor: a request is consumed when val and ack meet at the next edge
    always @(negedge clk) begin
        int      ch;
        tb_req_t r;
        if (rst_n && arb_l15_val && ack) begin
            if (exp_chid_q.size() == 0) begin
                chk("unexpected_issue_val", 64'(arb_l15_val), 64'd0);
            end else begin
                ch = exp_chid_q.pop_front();
                chk("issue_chid", 64'(arb_l15_chid), 64'(ch));
                if (exp_q[ch].size() == 0) begin
                    chk("issue_without_push_val", 64'(arb_l15_val), 64'd0);
                end else begin
                    r = exp_q[ch].pop_front();
                    chk("issue_rqtype", 64'(arb_l15_rqtype), 64'(r.rqtype));
                    chk("issue_size", 64'(arb_l15_size), 64'(r.size));
                    chk("issue_addr", 64'(arb_l15_address), 64'(r.addr));
                    chk("issue_data", arb_l15_data, r.data);
                    chk("issue_nc", 64'(arb_l15_nc), 64'(r.addr[39]));
                end
            end
        end
    end

    task automatic push_req(input int ch, input logic [4:0] rq, input logic [2:0] sz,
                            input logic [39:0] addr, input logic [63:0] data,
                            input logic exp_acc);
        tb_req_t r;
        ch_val[ch]             = 1'b1;
        ch_rqtype[ch*5 +: 5]   = rq;
        ch_size[ch*3 +: 3]     = sz;
        ch_addr[ch*PA_W +: PA_W] = addr;
        ch_data[ch*64 +: 64]   = data;
        chk("push_rdy", 64'(ch_rdy[ch]), 64'(exp_acc));
        @(posedge clk);
        #1;
        ch_val[ch] = 1'b0;
        if (exp_acc) begin
            r.rqtype = rq;
            r.size   = sz;
            r.addr   = addr;
            r.data   = data;
            exp_q[ch].push_back(r);
        end
    endtask

    task automatic drain(output int cyc);
        cyc = 0;
        @(posedge clk);
        #1 ack = 1'b1;
        while (exp_chid_q.size() != 0 && cyc < 60) begin
            @(posedge clk);
            cyc++;
        end
        #1 ack = 1'b0;
        chk("drain_left", 64'(exp_chid_q.size()), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst_n     = 1'b0;
        ch_val    = '0;
        ch_rqtype = '0;
        ch_size   = '0;
        ch_addr   = '0;
        ch_data   = '0;
        ack       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_val", 64'(arb_l15_val), 64'd0);
        chk("rst_addr", 64'(arb_l15_address), 64'd0);
        chk("rst_err", 64'(arb_err_spurious_ack), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ch_rdy", 64'(ch_rdy), 64'hF);

        // Single ifill on ch0: two-cycle latency, fields clear after ack
        exp_chid_q.push_back(0);
        push_req(0, 5'b10000, 3'b010, 40'h00_8000_0040, 64'h1111_2222_3333_4444, 1'b1);
        @(negedge clk);
        chk("t1_val_cycle1", 64'(arb_l15_val), 64'd0);
        @(negedge clk);
        chk("t1_val_cycle2", 64'(arb_l15_val), 64'd1);
        chk("t1_chid", 64'(arb_l15_chid), 64'd0);
        chk("t1_nc", 64'(arb_l15_nc), 64'd0);
        drain(cyc);
        @(negedge clk);
        chk("t1_val_after_ack", 64'(arb_l15_val), 64'd0);
        chk("t1_addr_cleared", 64'(arb_l15_address), 64'd0);
        chk("t1_rqtype_cleared", 64'(arb_l15_rqtype), 64'd0);
        chk("t1_size_cleared", 64'(arb_l15_size), 64'd0);
        chk("t1_data_cleared", arb_l15_data, 64'd0);

        // Non-cacheable store on ch2 held across un-acked cycles
        exp_chid_q.push_back(2);
        push_req(2, 5'b00001, 3'b011, 40'h80_0000_1000, 64'hDEADBEEF_CAFEF00D, 1'b1);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_hold_val", 64'(arb_l15_val), 64'd1);
            chk("t2_hold_addr", 64'(arb_l15_address), 64'h80_0000_1000);
            chk("t2_hold_data", arb_l15_data, 64'hDEADBEEF_CAFEF00D);
            chk("t2_hold_chid", 64'(arb_l15_chid), 64'd2);
        end
        chk("t2_nc", 64'(arb_l15_nc), 64'd1);
        drain(cyc);

        // Overfill ch1 while the output stage is held by a ch0 request
        exp_chid_q.push_back(0);
        push_req(0, 5'b00000, 3'b011, 40'h00_0000_0100, 64'hA0A0, 1'b1);
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (i < DEPTH) exp_chid_q.push_back(1);
            push_req(1, 5'b00000, 3'b011, 40'h00_0000_2000 + 40'(i * 8), 64'(i + 100),
                     (i < DEPTH));
        end
        drain(cyc);
        @(negedge clk);
        chk("t3_idle_after_drain", 64'(arb_l15_val), 64'd0);

        // Four channels, three requests each, ack every cycle
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                push_req(c, 5'b00000, 3'b011, 40'h01_0000_0000 + 40'(c * 256 + r * 8),
                         {32'(c), 32'(r)}, 1'b1);
            end
        end
`ifdef ANYCORE_ARB_RR_EN
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < NUM_CH; c++)
                exp_chid_q.push_back(c);
`else
        for (int c = 0; c < NUM_CH; c++)
            for (int r = 0; r < 3; r++)
                exp_chid_q.push_back(c);
`endif
        drain(cyc);
        chk("burst_cycles", 64'(cyc), 64'd12);

        // Ack while idle sets the sticky error flag only
        @(negedge clk);
        chk("err_before_spurious", 64'(arb_err_spurious_ack), 64'd0);
        @(posedge clk);
        #1 ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
        @(negedge clk);
        chk("err_set", 64'(arb_err_spurious_ack), 64'd1);
        chk("err_no_val", 64'(arb_l15_val), 64'd0);
        exp_chid_q.push_back(2);
        push_req(2, 5'b00001, 3'b011, 40'h00_0000_3000, 64'h0123_4567_89AB_CDEF, 1'b1);
        drain(cyc);
        chk("err_sticky", 64'(arb_err_spurious_ack), 64'd1);

        // Asynchronous reset while busy with two entries queued
        for (int i = 0; i < 3; i++) begin
            push_req(3, 5'b00000, 3'b011, 40'h00_0000_4000 + 40'(i * 8), 64'(i + 7), 1'b1);
        end
        chk("t6_busy_before_reset", 64'(arb_l15_val), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_async_val", 64'(arb_l15_val), 64'd0);
        chk("t6_async_addr", 64'(arb_l15_address), 64'd0);
        chk("t6_async_data", arb_l15_data, 64'd0);
        chk("t6_async_chid", 64'(arb_l15_chid), 64'd0);
        chk("t6_async_err", 64'(arb_err_spurious_ack), 64'd0);
        exp_q[3].delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_ch_rdy", 64'(ch_rdy), 64'hF);
        repeat (5) @(posedge clk);
        #1;
        chk("t6_no_stale_val", 64'(arb_l15_val), 64'd0);
        exp_chid_q.push_back(3);
        push_req(3, 5'b10000, 3'b010, 40'h00_0000_5000, 64'h55, 1'b1);
        drain(cyc);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
